hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage RV32I core.
- Watches the IF/ID, ID/EX and EX stages. Decides each cycle whether PC and IF/ID advance, stall or flush.
- Drives the decode stage's control-zeroing input (i_ctr_SetCtlZero) to inject bubbles.
- Freezes the whole pipeline while data memory is busy and replays a pending redirect once memory releases.

---
 rtl/hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencer for the 5-stage RV32I core. It decides each
//            cycle whether PC and IF/ID advance, stall or flush. It injects
//            decode bubbles and freezes the pipeline while data memory is
//            busy. A redirect that arrives during a memory freeze is
//            replayed once memory releases.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FLUSH_CYCLES : extra IF/ID flush cycles after a redirect (0..7)
//   CNT_WIDTH    : width of the performance counters
// Ports
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   i_id_Valid      : IF/ID holds a real instruction
//   i_id_Reg1/Reg2  : rs1/rs2 of the IF/ID instruction
//   i_ex_MemRead    : ID/EX instruction is a load
//   i_ex_RegDst     : rd of the ID/EX instruction
//   i_ex_Redirect   : taken branch / jump resolved in EX
//   i_mem_Busy      : data memory not ready, MEM must hold
//   o_PcWrEn/o_PcSel: PC load enable / redirect-target select
//   o_IfIdWrEn      : IF/ID load enable
//   o_IfIdFlush     : IF/ID loads a NOP
//   o_SetCtlZero    : decode injects a bubble into ID/EX
//   o_PipeHold      : ID/EX, EX/MEM, MEM/WB hold
//   o_StallCnt      : load-use stall cycles (perf feature)
//   o_FlushCnt      : redirects applied (perf feature)
// Build option
//   HAZARD_PERF_CNT_EN : when defined, builds saturating performance
//                        counters; otherwise both counter ports read 0.
// ============================================================================
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_id_Valid,
   input  logic [4:0]           i_id_Reg1,
   input  logic [4:0]           i_id_Reg2,
   input  logic                 i_ex_MemRead,
   input  logic [4:0]           i_ex_RegDst,
   input  logic                 i_ex_Redirect,
   input  logic                 i_mem_Busy,
   output logic                 o_PcWrEn,
   output logic                 o_PcSel,
   output logic                 o_IfIdWrEn,
   output logic                 o_IfIdFlush,
   output logic                 o_SetCtlZero,
   output logic                 o_PipeHold,
   output logic [CNT_WIDTH-1:0] o_StallCnt,
   output logic [CNT_WIDTH-1:0] o_FlushCnt
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_FLUSH   = 2'd1,
      S_MEMWAIT = 2'd2
   } state_t;

   localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_flush_cnt;
   logic [2:0] w_flush_cnt_nxt;
   logic       r_pending;
   logic       w_pending_nxt;
   logic       w_load_use;
   logic       w_redir;

   // x0 as destination never creates a dependency.
   assign w_load_use = i_id_Valid & i_ex_MemRead & (i_ex_RegDst != 5'd0) &
                       ((i_ex_RegDst == i_id_Reg1) | (i_ex_RegDst == i_id_Reg2));

   // A redirect seen during a memory freeze is held in r_pending and
   // applied on the first free cycle.
   assign w_redir = i_ex_Redirect | r_pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_RUN;
         r_flush_cnt <= 3'd0;
         r_pending   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
         r_pending   <= w_pending_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      w_pending_nxt   = r_pending;
      o_PcWrEn        = 1'b1;
      o_PcSel         = 1'b0;
      o_IfIdWrEn      = 1'b1;
      o_IfIdFlush     = 1'b0;
      o_SetCtlZero    = 1'b0;
      o_PipeHold      = 1'b0;

      if (reset) begin
         // Keep fetch quiet and decode bubbled while reset is applied.
         o_PcWrEn        = 1'b0;
         o_IfIdWrEn      = 1'b0;
         o_IfIdFlush     = 1'b1;
         o_SetCtlZero    = 1'b1;
         w_state_nxt     = S_RUN;
         w_flush_cnt_nxt = 3'd0;
         w_pending_nxt   = 1'b0;
      end else if (i_mem_Busy) begin
         // Whole-pipeline freeze; the same behaviour applies in every
         // state, including S_MEMWAIT.
         o_PcWrEn      = 1'b0;
         o_IfIdWrEn    = 1'b0;
         o_PipeHold    = 1'b1;
         w_pending_nxt = r_pending | i_ex_Redirect;
         w_state_nxt   = S_MEMWAIT;
      end else if (w_redir) begin
         // A redirect outranks both a flush in progress and a load-use stall.
         o_PcSel       = 1'b1;
         o_IfIdFlush   = 1'b1;
         o_SetCtlZero  = 1'b1;
         w_pending_nxt = 1'b0;
         if (FLUSH_CYCLES > 0) begin
            w_flush_cnt_nxt = c_FLUSH_LOAD;
            w_state_nxt     = S_FLUSH;
         end else begin
            w_state_nxt = S_RUN;
         end
      end else if (r_state == S_FLUSH) begin
         // Kill the wrong-path words still returning from synchronous imem.
         // A load-use match is ignored here because IF/ID is being discarded.
         o_IfIdFlush     = 1'b1;
         o_SetCtlZero    = 1'b1;
         w_flush_cnt_nxt = r_flush_cnt - 3'd1;
         if (r_flush_cnt <= 3'd1) begin
            w_state_nxt = S_RUN;
         end
      end else begin
         // S_RUN, or S_MEMWAIT released without a redirect.
         w_state_nxt = S_RUN;
         if (w_load_use) begin
            // One bubble is enough: next cycle the load is in EX/MEM.
            o_PcWrEn     = 1'b0;
            o_IfIdWrEn   = 1'b0;
            o_SetCtlZero = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_redir_cnt;
   logic                 w_stall_evt;
   logic                 w_redir_evt;

   // The bubble-with-PC-frozen pattern occurs only for a load-use stall,
   // and PcSel is high only on a redirect-apply cycle. During reset the
   // counters are held cleared, so the forced reset outputs never count.
   assign w_stall_evt = o_SetCtlZero & ~o_PcWrEn;
   assign w_redir_evt = o_PcSel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_redir_cnt <= '0;
      end else begin
         if (w_stall_evt && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         end
         if (w_redir_evt && !(&r_redir_cnt)) begin
            r_redir_cnt <= r_redir_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign o_StallCnt = r_stall_cnt;
   assign o_FlushCnt = r_redir_cnt;
`else
   assign o_StallCnt = '0;
   assign o_FlushCnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Scoreboard bench for hazard_ctrl. Three instances share the
//            same stimulus:
//              - FLUSH_CYCLES=1, 16-bit counters
//              - FLUSH_CYCLES=3, 3-bit counters, to reach counter saturation
//              - FLUSH_CYCLES=0, 16-bit counters
//            A cycle-level reference model predicts the outputs of each
//            instance. The stimulus process queues the predictions, and a
//            monitor process compares them with the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int NDUT = 3;

   typedef struct packed {
      logic [7:0]  k;
      logic [5:0]  ctl;   // {PcWrEn, PcSel, IfIdWrEn, IfIdFlush, SetCtlZero, PipeHold}
      logic [15:0] sc;
      logic [15:0] fc;
      logic [31:0] cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_r1 = 5'd0;
   logic [4:0] id_r2 = 5'd0;
   logic       ex_mr = 1'b0;
   logic [4:0] ex_rd = 5'd0;
   logic       ex_redir = 1'b0;
   logic       mem_busy = 1'b0;

   wire [5:0]  ctl0, ctl1, ctl2;
   wire [15:0] sc0, fc0, sc2, fc2;
   wire [2:0]  sc1, fc1;

   exp_t  sbq[$];
   string tagq[$];
   int    ntests = 0;
   int    nfail  = 0;
   int    cyc_n  = 0;

   // Reference-model state: remaining flush cycles, a pending redirect, and
   // event counts since the last reset.
   int    m_flush_left [NDUT];
   bit    m_pending    [NDUT];
   int    m_scnt       [NDUT];
   int    m_fcnt       [NDUT];

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(16)) u_dut0 (
      .clk(clk), .reset(rst), .i_id_Valid(id_valid), .i_id_Reg1(id_r1),
      .i_id_Reg2(id_r2), .i_ex_MemRead(ex_mr), .i_ex_RegDst(ex_rd),
      .i_ex_Redirect(ex_redir), .i_mem_Busy(mem_busy),
      .o_PcWrEn(ctl0[5]), .o_PcSel(ctl0[4]), .o_IfIdWrEn(ctl0[3]),
      .o_IfIdFlush(ctl0[2]), .o_SetCtlZero(ctl0[1]), .o_PipeHold(ctl0[0]),
      .o_StallCnt(sc0), .o_FlushCnt(fc0));

   hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(3)) u_dut1 (
      .clk(clk), .reset(rst), .i_id_Valid(id_valid), .i_id_Reg1(id_r1),
      .i_id_Reg2(id_r2), .i_ex_MemRead(ex_mr), .i_ex_RegDst(ex_rd),
      .i_ex_Redirect(ex_redir), .i_mem_Busy(mem_busy),
      .o_PcWrEn(ctl1[5]), .o_PcSel(ctl1[4]), .o_IfIdWrEn(ctl1[3]),
      .o_IfIdFlush(ctl1[2]), .o_SetCtlZero(ctl1[1]), .o_PipeHold(ctl1[0]),
      .o_StallCnt(sc1), .o_FlushCnt(fc1));

   hazard_ctrl #(.FLUSH_CYCLES(0), .CNT_WIDTH(16)) u_dut2 (
      .clk(clk), .reset(rst), .i_id_Valid(id_valid), .i_id_Reg1(id_r1),
      .i_id_Reg2(id_r2), .i_ex_MemRead(ex_mr), .i_ex_RegDst(ex_rd),
      .i_ex_Redirect(ex_redir), .i_mem_Busy(mem_busy),
      .o_PcWrEn(ctl2[5]), .o_PcSel(ctl2[4]), .o_IfIdWrEn(ctl2[3]),
      .o_IfIdFlush(ctl2[2]), .o_SetCtlZero(ctl2[1]), .o_PipeHold(ctl2[0]),
      .o_StallCnt(sc2), .o_FlushCnt(fc2));

   function automatic int flush_of(input int k);
      case (k)
         0:       return 1;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   function automatic int cmax_of(input int k);
      return (k == 1) ? 7 : 65535;
   endfunction

   function automatic logic [5:0] act_ctl(input int k);
      case (k)
         0:       return ctl0;
         1:       return ctl1;
         default: return ctl2;
      endcase
   endfunction

   function automatic logic [15:0] act_sc(input int k);
      case (k)
         0:       return sc0;
         1:       return {13'd0, sc1};
         default: return sc2;
      endcase
   endfunction

   function automatic logic [15:0] act_fc(input int k);
      case (k)
         0:       return fc0;
         1:       return {13'd0, fc1};
         default: return fc2;
      endcase
   endfunction

   // Behavioural rules for one cycle of instance k, using the inputs
   // currently driven. The counters are registered, so the predicted
   // counter values are the counts from before this cycle.
   task automatic model(input int k, output exp_t e);
      bit lu;
      bit redir;
      e     = '0;
      e.k   = 8'(k);
      e.cyc = 32'(cyc_n);
`ifdef HAZARD_PERF_CNT_EN
      e.sc  = 16'(m_scnt[k]);
      e.fc  = 16'(m_fcnt[k]);
`endif
      lu    = id_valid && ex_mr && (ex_rd != 0) && (ex_rd == id_r1 || ex_rd == id_r2);
      redir = ex_redir || m_pending[k];
      if (rst) begin
         e.ctl = 6'b000110;
         e.sc  = 16'd0;
         e.fc  = 16'd0;
         m_flush_left[k] = 0;
         m_pending[k]    = 1'b0;
         m_scnt[k]       = 0;
         m_fcnt[k]       = 0;
      end else if (mem_busy) begin
         e.ctl = 6'b000001;
         m_pending[k]    = m_pending[k] || ex_redir;
         m_flush_left[k] = 0;     // the freeze ends any flush in progress
      end else if (redir) begin
         e.ctl = 6'b111110;
         m_pending[k]    = 1'b0;
         m_flush_left[k] = flush_of(k);
         if (m_fcnt[k] < cmax_of(k)) m_fcnt[k]++;
      end else if (m_flush_left[k] > 0) begin
         e.ctl = 6'b101110;
         m_flush_left[k]--;
      end else if (lu) begin
         e.ctl = 6'b000010;
         if (m_scnt[k] < cmax_of(k)) m_scnt[k]++;
      end else begin
         e.ctl = 6'b101000;
      end
   endtask

   task automatic cyc(input string tag, input logic r, input logic v,
                      input logic [4:0] a, input logic [4:0] b, input logic m,
                      input logic [4:0] d, input logic x, input logic bz);
      @(posedge clk);
      #1;
      cyc_n++;
      rst = r; id_valid = v; id_r1 = a; id_r2 = b;
      ex_mr = m; ex_rd = d; ex_redir = x; mem_busy = bz;
      for (int k = 0; k < NDUT; k++) begin
         exp_t e;
         model(k, e);
         sbq.push_back(e);
         tagq.push_back(tag);
      end
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
   endtask

   // Monitor: compares every queued prediction at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         while (sbq.size() > 0) begin
            exp_t        e;
            string       t;
            int          k;
            logic [5:0]  gc;
            logic [15:0] gs;
            logic [15:0] gf;
            e  = sbq.pop_front();
            t  = tagq.pop_front();
            k  = int'(e.k);
            gc = act_ctl(k);
            gs = act_sc(k);
            gf = act_fc(k);
            ntests++;
            if (gc !== e.ctl || gs !== e.sc || gf !== e.fc) begin
               nfail++;
               $display("FAIL %s dut%0d cyc%0d: ctl got %b want %b, stallcnt got %0d want %0d, flushcnt got %0d want %0d",
                        t, k, e.cyc, gc, e.ctl, gs, e.sc, gf, e.fc);
            end
         end
      end
   end

   initial begin
      int busy_left;
      for (int k = 0; k < NDUT; k++) begin
         m_flush_left[k] = 0; m_pending[k] = 1'b0; m_scnt[k] = 0; m_fcnt[k] = 0;
      end

      // Reset state.
      cyc("reset", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      cyc("reset", 1'b1, 1'b1, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
      idle("post_reset", 2);
      // Load-use on rs2, then the load has moved on.
      cyc("loaduse", 1'b0, 1'b1, 5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
      cyc("loaduse_after", 1'b0, 1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
      // x0 destination and non-load producer: no stall.
      cyc("x0_dst", 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      cyc("non_load", 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0);
      cyc("invalid_id", 1'b0, 1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
      // Redirect pulse followed by its flush window.
      cyc("redirect", 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
      idle("redirect_flush", 4);
      // Busy for three cycles with a redirect in the first one.
      cyc("busy_redir", 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1);
      cyc("busy", 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1);
      cyc("busy", 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1);
      idle("busy_replay", 5);
      // Redirect and load-use together.
      cyc("redir_and_lu", 1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
      idle("redir_and_lu_after", 4);
      // Load-use inside the flush window is ignored.
      cyc("redirect", 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
      cyc("flush_lu", 1'b0, 1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
      idle("flush_lu_after", 3);
      // Reset while a flush and a pending redirect are outstanding.
      cyc("redirect", 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
      cyc("busy_pend", 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1);
      cyc("mid_reset", 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
      idle("after_reset", 5);

      // Randomized traffic with a small register space to provoke hazards.
      busy_left = 0;
      for (int i = 0; i < 3000; i++) begin
         logic bz;
         if (busy_left > 0) begin
            bz = 1'b1;
            busy_left--;
         end else if ($urandom_range(9) == 0) begin
            bz = 1'b1;
            busy_left = int'($urandom_range(3));
         end else begin
            bz = 1'b0;
         end
         cyc("random", ($urandom_range(299) == 0), ($urandom_range(4) != 0),
             5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom),
             5'($urandom_range(3)), ($urandom_range(7) == 0), bz);
      end

      @(negedge clk);
      #1;
      ntests++;
      if (sbq.size() != 0) begin
         nfail++;
         $display("FAIL drain: %0d predictions left unchecked, want 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
`default_nettype wire
